// File: rtl/twi_arbiter.sv
// Purpose: shares one twi_master between N_REQ requesters; round-robin grant, or fixed priority with TWI_ARB_FIXED_PRIO_EN.
// Latency: req in cycle k -> m_wr/m_rd in cycle k+1; ack one cycle after the m_tr edge; next grant no sooner than 2 cycles after m_tr.
// Backpressure: requesters hold req until their ack; a granted transfer runs to m_tr and ignores req/field changes meanwhile.
module twi_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   we,
    input  logic [7*N_REQ-1:0] chip_addr,
    input  logic [8*N_REQ-1:0] reg_addr,
    input  logic [8*N_REQ-1:0] wdata,
    output logic [N_REQ-1:0]   ack,
    output logic [7:0]         rdata,
    output logic               busy,
    output logic [ID_W-1:0]    gnt_id,
    output logic [6:0]         m_chip_addr,
    output logic [7:0]         m_reg_addr,
    output logic [7:0]         m_datain,
    output logic               m_wr,
    output logic               m_rd,
    input  logic               m_tr,
    output logic               m_tr_clr,
    input  logic [7:0]         m_dataout
);

    typedef enum logic [1:0] {IDLE, ISSUE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   win;
    logic [6:0]        sel_chip;
    logic [7:0]        sel_reg;
    logic [7:0]        sel_wdata;
    logic              sel_we;

    logic [N_REQ-1:0]  ack_nxt;
    logic [7:0]        rdata_nxt;
    logic              busy_nxt;
    logic [ID_W-1:0]   gnt_nxt;
    logic [6:0]        chip_nxt;
    logic [7:0]        reg_nxt;
    logic [7:0]        dat_nxt;
    logic              wr_nxt;
    logic              rd_nxt;
    logic              clr_nxt;

`ifdef TWI_ARB_FIXED_PRIO_EN
    // Winner is the lowest-numbered pending requester.
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) win = ID_W'(i);
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_ptr_nxt;
    int              rr_dist;
    int              rr_best;

    // Winner is the pending requester closest after rr_ptr, wrapping modulo N_REQ;
    // rr_ptr itself is the farthest, so the last owner goes to the back of the line.
    always_comb begin
        win     = '0;
        rr_best = N_REQ;
        rr_dist = 0;
        for (int i = 0; i < N_REQ; i++) begin
            rr_dist = i - int'(rr_ptr) - 1;
            if (rr_dist < 0) rr_dist = rr_dist + N_REQ;
            if (req[i] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                win     = ID_W'(i);
            end
        end
    end

    // Pointer moves to the owner once its transfer completes.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (state == ISSUE && m_tr) rr_ptr_nxt = gnt_id;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= ID_W'(N_REQ - 1);
        else     rr_ptr <= rr_ptr_nxt;
    end
`endif

    // Mux out the winner's request fields.
    always_comb begin
        sel_chip  = '0;
        sel_reg   = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == win) begin
                sel_chip  = chip_addr[7*i +: 7];
                sel_reg   = reg_addr[8*i +: 8];
                sel_wdata = wdata[8*i +: 8];
                sel_we    = we[i];
            end
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt = state;
        ack_nxt   = '0;
        rdata_nxt = rdata;
        gnt_nxt   = gnt_id;
        chip_nxt  = m_chip_addr;
        reg_nxt   = m_reg_addr;
        dat_nxt   = m_datain;
        wr_nxt    = m_wr;
        rd_nxt    = m_rd;
        clr_nxt   = m_tr_clr;
        case (state)
            IDLE: begin
                clr_nxt = 1'b0;
                wr_nxt  = 1'b0;
                rd_nxt  = 1'b0;
                if (|req) begin
                    state_nxt = ISSUE;
                    gnt_nxt   = win;
                    chip_nxt  = sel_chip;
                    reg_nxt   = sel_reg;
                    dat_nxt   = sel_wdata;
                    wr_nxt    = sel_we;
                    rd_nxt    = ~sel_we;
                end
            end
            ISSUE: begin
                if (m_tr) begin
                    state_nxt = CLEAR;
                    wr_nxt    = 1'b0;
                    rd_nxt    = 1'b0;
                    clr_nxt   = 1'b1;
                    rdata_nxt = m_dataout;
                    for (int i = 0; i < N_REQ; i++) begin
                        ack_nxt[i] = (ID_W'(i) == gnt_id);
                    end
                end
            end
            CLEAR: begin
                // Hold tr_clr one more cycle so the master cannot relaunch on stale wr/rd.
                clr_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Output registers; reset keeps tr_clr high so the master stays parked.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack         <= '0;
            rdata       <= '0;
            busy        <= 1'b0;
            gnt_id      <= '0;
            m_chip_addr <= '0;
            m_reg_addr  <= '0;
            m_datain    <= '0;
            m_wr        <= 1'b0;
            m_rd        <= 1'b0;
            m_tr_clr    <= 1'b1;
        end else begin
            ack         <= ack_nxt;
            rdata       <= rdata_nxt;
            busy        <= busy_nxt;
            gnt_id      <= gnt_nxt;
            m_chip_addr <= chip_nxt;
            m_reg_addr  <= reg_nxt;
            m_datain    <= dat_nxt;
            m_wr        <= wr_nxt;
            m_rd        <= rd_nxt;
            m_tr_clr    <= clr_nxt;
        end
    end

endmodule
